// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger cluster path: cluster packing, idle
// cluster code, orbit length and the ring-buffer entry layout.
package trigger_pkg;

    localparam int CLUSTER_W     = 14;
    localparam int NCLUSTERS     = 8;
    localparam int CLUSTERS_W    = CLUSTER_W * NCLUSTERS;
    localparam int BXN_W         = 12;
    localparam int MAXBX_DEFAULT = 3563;

    // adr[10:9] == 2'b11 marks a cluster as invalid downstream
    localparam logic [CLUSTER_W-1:0]  IDLE_CLUSTER = 14'h07FF;
    localparam logic [CLUSTERS_W-1:0] IDLE_ALL     = {NCLUSTERS{IDLE_CLUSTER}};

    // One BX worth of data as it travels through the delay ring
    typedef struct packed {
        logic                  ovf;
        logic [BXN_W-1:0]      bxn;
        logic [CLUSTERS_W-1:0] clusters;
    } ring_entry_t;

    function automatic logic cluster_valid(input logic [CLUSTER_W-1:0] c);
        return !(c[10] && c[9]);
    endfunction

endpackage

// File: rtl/cluster_ring_ram.sv
// Delay ring storage: DEPTH entries, one write port and one registered
// read port, intended to map onto a block RAM.
module cluster_ring_ram
    import trigger_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_40,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  ring_entry_t   wr_data,
    input  logic [AW-1:0] rd_addr,
    output ring_entry_t   rd_data
);

    ring_entry_t mem [DEPTH];

    // Write and synchronous read; contents are never cleared
    always_ff @(posedge clk_40) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/trigger_cluster_delay.sv
// Programmable BX delay for the 8 sorted clusters feeding trigger_links.
// Tags each BX with the free-running bxn, delays it by delay_sel BX through
// a ring buffer (total latency delay_sel + 2), mutes output until the ring
// holds valid data for the selected delay, and stretches overflow.
module trigger_cluster_delay
    import trigger_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int MAXBX      = MAXBX_DEFAULT,
    parameter int BX0_OFFSET = 0,
    parameter int OVF_HOLD   = 4
) (
    input  logic                     clk_40,
    input  logic                     reset_i,
    input  logic                     ttc_bx0,
    input  logic [CLUSTERS_W-1:0]    clusters_i,
    input  logic                     overflow_i,
    input  logic [$clog2(DEPTH)-1:0] delay_sel,
    input  logic                     trig_stop,
    output logic [CLUSTERS_W-1:0]    clusters_o,
    output logic [BXN_W-1:0]         bxn_counter,
    output logic                     bx0_o,
    output logic                     overflow_o,
    output logic [3:0]               cluster_count,
    output logic                     bx0_sync_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int HOLD_W = $clog2(OVF_HOLD + 1);

    localparam logic [BXN_W-1:0]  MAXBX_V     = BXN_W'(MAXBX);
    localparam logic [BXN_W-1:0]  BX0_V       = BXN_W'(BX0_OFFSET);
    localparam logic [AW-1:0]     FILL_MAX    = AW'(DEPTH - 1);
    // The cycle that sees the tag already drives overflow_o high, so the
    // counter only needs to cover the remaining OVF_HOLD-1 cycles.
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(OVF_HOLD - 1);

    logic [BXN_W-1:0]      bxn_free_reg;
    ring_entry_t           in_reg;
    ring_entry_t           byp_reg;
    ring_entry_t           ram_q;
    ring_entry_t           rd_entry;
    logic                  byp_sel_reg;
    logic [AW-1:0]         delay_reg;
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         fill_reg;
    logic [HOLD_W-1:0]     hold_reg;
    logic                  mute_fill;
    logic                  mute_data;
    logic [NCLUSTERS-1:0]  valid_vec;
    logic [3:0]            count_next;
    logic [CLUSTERS_W-1:0] clusters_next;

    // Free-running bxn counter; ttc_bx0 realigns it and flags a misaligned orbit
    always_ff @(posedge clk_40) begin
        if (reset_i) begin
            bxn_free_reg <= '0;
            bx0_sync_err <= 1'b0;
        end else begin
            if (ttc_bx0) begin
                bxn_free_reg <= BX0_V;
                if (bxn_free_reg != MAXBX_V) begin
                    bx0_sync_err <= 1'b1;
                end
            end else if (bxn_free_reg == MAXBX_V) begin
                bxn_free_reg <= '0;
            end else begin
                bxn_free_reg <= bxn_free_reg + 1'b1;
            end
        end
    end

    // Input stage and delay_sel capture; pure data path, so no reset
    always_ff @(posedge clk_40) begin
        in_reg.ovf      <= overflow_i;
        in_reg.bxn      <= bxn_free_reg;
        in_reg.clusters <= clusters_i;
        delay_reg       <= delay_sel;
    end

    // Write pointer advances every BX; fill count restarts on reset or delay change
    always_ff @(posedge clk_40) begin
        if (reset_i) begin
            wr_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (delay_sel != delay_reg) begin
                fill_reg <= '0;
            end else if (fill_reg != FILL_MAX) begin
                fill_reg <= fill_reg + 1'b1;
            end
        end
    end

    // Zero-delay path skips the RAM, whose read would collide with the write
    always_ff @(posedge clk_40) begin
        byp_reg     <= in_reg;
        byp_sel_reg <= (delay_reg == '0);
    end

    assign rd_addr = wr_ptr_reg - delay_reg;

    cluster_ring_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ring (
        .clk_40  (clk_40),
        .we      (1'b1),
        .wr_addr (wr_ptr_reg),
        .wr_data (in_reg),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    assign rd_entry = byp_sel_reg ? byp_reg : ram_q;

    // Mute until delay_sel+1 BX have passed since the last restart. A
    // saturated fill count always releases, so the maximum delay cannot
    // leave the output muted forever.
    assign mute_fill = (fill_reg <= delay_reg) && (fill_reg != FILL_MAX);
    assign mute_data = mute_fill || trig_stop;

    genvar gi;
    generate
        for (gi = 0; gi < NCLUSTERS; gi++) begin : g_cluster
            logic [CLUSTER_W-1:0] c;
            assign c              = rd_entry.clusters[gi*CLUSTER_W +: CLUSTER_W];
            assign valid_vec[gi]  = cluster_valid(c);
            assign clusters_next[gi*CLUSTER_W +: CLUSTER_W] = mute_data ? IDLE_CLUSTER : c;
        end
    endgenerate

    // Number of valid clusters in the BX leaving the ring
    always_comb begin
        count_next = '0;
        for (int i = 0; i < NCLUSTERS; i++) begin
            count_next = count_next + {3'b000, valid_vec[i]};
        end
    end

    // Output registers: clusters, count, tags and stretched overflow move together
    always_ff @(posedge clk_40) begin
        if (reset_i) begin
            clusters_o    <= IDLE_ALL;
            cluster_count <= '0;
            bxn_counter   <= '0;
            bx0_o         <= 1'b0;
            overflow_o    <= 1'b0;
            hold_reg      <= '0;
        end else begin
            clusters_o    <= clusters_next;
            cluster_count <= mute_data ? 4'd0 : count_next;
            bxn_counter   <= rd_entry.bxn;
            bx0_o         <= !mute_fill && (rd_entry.bxn == BX0_V);
            if (rd_entry.ovf) begin
                hold_reg <= HOLD_RELOAD;
            end else if (hold_reg != '0) begin
                hold_reg <= hold_reg - 1'b1;
            end
            overflow_o    <= (rd_entry.ovf || (hold_reg != '0)) && !mute_data;
        end
    end

endmodule

// File: tb/tb_trigger_cluster_delay.sv
// Directed bench for trigger_cluster_delay: latency per delay setting,
// fill guard, bxn/bx0 orbit handling, overflow stretch, trig_stop and reset.
module tb_trigger_cluster_delay;

    logic         clk_40 = 1'b0;
    logic         reset_i;
    logic         ttc_bx0;
    logic [111:0] clusters_i;
    logic         overflow_i;
    logic [3:0]   delay_sel;
    logic         trig_stop;
    logic [111:0] clusters_o;
    logic [11:0]  bxn_counter;
    logic         bx0_o;
    logic         overflow_o;
    logic [3:0]   cluster_count;
    logic         bx0_sync_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    localparam logic [111:0] ALL_IDLE = {8{14'h07FF}};

    always #5 clk_40 = ~clk_40;

    trigger_cluster_delay dut (
        .clk_40        (clk_40),
        .reset_i       (reset_i),
        .ttc_bx0       (ttc_bx0),
        .clusters_i    (clusters_i),
        .overflow_i    (overflow_i),
        .delay_sel     (delay_sel),
        .trig_stop     (trig_stop),
        .clusters_o    (clusters_o),
        .bxn_counter   (bxn_counter),
        .bx0_o         (bx0_o),
        .overflow_o    (overflow_o),
        .cluster_count (cluster_count),
        .bx0_sync_err  (bx0_sync_err)
    );

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk_40);
        #1;
        cyc++;
    endtask

    function automatic logic [111:0] mk(input logic [13:0] c0);
        return {{7{14'h07FF}}, c0};
    endfunction

    // Stream value driven for the input edge numbered e (always a valid cluster)
    function automatic logic [13:0] sv(input int e);
        return 14'(256 + (e % 1024));
    endfunction

    function automatic logic [111:0] pat_all();
        logic [111:0] p;
        for (int i = 0; i < 8; i++) p[i*14 +: 14] = 14'(16 * (i + 1));
        return p;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, p, b, bad, pulses;
        logic ex;

        reset_i = 1'b1; ttc_bx0 = 1'b0; overflow_i = 1'b0; trig_stop = 1'b0;
        delay_sel = 4'd0; clusters_i = ALL_IDLE;
        repeat (3) step();

        // Reset values
        chk("rst_clusters", clusters_o, ALL_IDLE);
        chk("rst_bxn", 112'(bxn_counter), 112'(0));
        chk("rst_bx0", 112'(bx0_o), 112'(0));
        chk("rst_ovf", 112'(overflow_o), 112'(0));
        chk("rst_cnt", 112'(cluster_count), 112'(0));
        chk("rst_err", 112'(bx0_sync_err), 112'(0));

        // Test 1: delay 0, single cluster appears exactly 2 cycles later
        r = cyc; reset_i = 1'b0; clusters_i = mk(14'h0123);
        step(); clusters_i = ALL_IDLE;
        step(); chk("t1_early", clusters_o, ALL_IDLE);
        step();
        chk("t1_c0", clusters_o, mk(14'h0123));
        chk("t1_cnt", 112'(cluster_count), 112'(1));
        chk("t1_bxn", 112'(bxn_counter), 112'(0));
        chk("t1_bx0", 112'(bx0_o), 112'(1));
        step(); chk("t1_after", clusters_o, ALL_IDLE);
        clusters_i = pat_all();
        repeat (20) step();
        chk("t1_all8", clusters_o, pat_all());
        chk("t1_cnt8", 112'(cluster_count), 112'(8));

        // Test 2: delay 5 after reset, counting pattern, 6 muted cycles
        reset_i = 1'b1; delay_sel = 4'd5;
        repeat (2) step();
        r = cyc; reset_i = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            clusters_i = mk(sv(cyc + 1));
            step();
            if (j <= 6) begin
                chk("t2_guard", clusters_o, ALL_IDLE);
            end else if (j >= 8) begin
                chk("t2_data", clusters_o, mk(sv(cyc - 7)));
                chk("t2_bxn", 112'(bxn_counter), 112'(cyc - 7 - r - 1));
            end
        end

        // Test 5: delay 5 -> 3, then 3 -> 9 mid-stream
        delay_sel = 4'd3; c = cyc + 1;
        for (int j = 1; j <= 14; j++) begin
            clusters_i = mk(sv(cyc + 1));
            step();
            if (cyc >= c + 1 && cyc <= c + 4) begin
                chk("t5_guard3", clusters_o, ALL_IDLE);
            end else if (cyc >= c + 5) begin
                chk("t5_data3", clusters_o, mk(sv(cyc - 5)));
            end
        end
        delay_sel = 4'd9; c = cyc + 1;
        for (int j = 1; j <= 22; j++) begin
            clusters_i = mk(sv(cyc + 1));
            step();
            if (cyc >= c + 1 && cyc <= c + 10) begin
                chk("t5_guard9", clusters_o, ALL_IDLE);
            end else if (cyc >= c + 11) begin
                chk("t5_data9", clusters_o, mk(sv(cyc - 11)));
                chk("t5_bxn9", 112'(bxn_counter), 112'(cyc - 11 - r - 1));
            end
        end

        // Test 4: overflow stretch with delay 2; pulses at offsets 0, 12, 14
        delay_sel = 4'd2;
        for (int j = 1; j <= 8; j++) begin
            clusters_i = mk(sv(cyc + 1));
            step();
        end
        p = cyc + 1;
        for (int k = 0; k < 26; k++) begin
            clusters_i = mk(sv(cyc + 1));
            overflow_i = (k == 0 || k == 12 || k == 14);
            step();
            ex = (k >= 4 && k <= 7) || (k >= 16 && k <= 21);
            chk("t4_ovf", 112'(overflow_o), 112'(ex));
        end
        overflow_i = 1'b0;
        chk("t4_data", clusters_o, mk(sv(cyc - 4)));

        // Test 3: two full orbits with aligned bx0, then an early bx0
        reset_i = 1'b1; delay_sel = 4'd0; clusters_i = ALL_IDLE;
        repeat (2) step();
        r = cyc; reset_i = 1'b0; bad = 0; pulses = 0;
        for (int j = 1; j <= 7140; j++) begin
            ttc_bx0 = ((j % 3564) == 0);
            step();
            if (j >= 3) begin
                if (bxn_counter !== 12'((j - 3) % 3564)) bad++;
                if (bx0_o) pulses++;
            end
        end
        ttc_bx0 = 1'b0;
        chk("t3_bxn_seq_errors", 112'(bad), 112'(0));
        chk("t3_bx0_pulses", 112'(pulses), 112'(3));
        chk("t3_err_clear", 112'(bx0_sync_err), 112'(0));
        repeat (88) step();
        ttc_bx0 = 1'b1;
        step();
        b = cyc; ttc_bx0 = 1'b0;
        chk("t3_err_set", 112'(bx0_sync_err), 112'(1));
        step(); step();
        chk("t3_bxn_100", 112'(bxn_counter), 112'(100));
        step();
        chk("t3_bxn_reload", 112'(bxn_counter), 112'(0));
        chk("t3_bx0_reload", 112'(bx0_o), 112'(1));
        repeat (5) step();
        chk("t3_err_sticky", 112'(bx0_sync_err), 112'(1));

        // Test 6: trig_stop with 8 valid clusters, then reset mid-stream
        clusters_i = pat_all(); overflow_i = 1'b1;
        repeat (4) step();
        chk("t6_pre_cl", clusters_o, pat_all());
        chk("t6_pre_cnt", 112'(cluster_count), 112'(8));
        chk("t6_pre_ovf", 112'(overflow_o), 112'(1));
        trig_stop = 1'b1;
        step();
        chk("t6_stop_cl", clusters_o, ALL_IDLE);
        chk("t6_stop_cnt", 112'(cluster_count), 112'(0));
        chk("t6_stop_ovf", 112'(overflow_o), 112'(0));
        step(); step();
        chk("t6_stop_hold", clusters_o, ALL_IDLE);
        trig_stop = 1'b0;
        step();
        chk("t6_resume_cl", clusters_o, pat_all());
        chk("t6_resume_cnt", 112'(cluster_count), 112'(8));
        reset_i = 1'b1;
        step();
        chk("t6_rst_cl", clusters_o, ALL_IDLE);
        chk("t6_rst_bxn", 112'(bxn_counter), 112'(0));
        chk("t6_rst_bx0", 112'(bx0_o), 112'(0));
        chk("t6_rst_ovf", 112'(overflow_o), 112'(0));
        chk("t6_rst_cnt", 112'(cluster_count), 112'(0));
        chk("t6_rst_err", 112'(bx0_sync_err), 112'(0));
        reset_i = 1'b0;
        step();
        chk("t6_rearm", clusters_o, ALL_IDLE);
        step();
        chk("t6_after_rearm", clusters_o, pat_all());
        chk("t6_after_cnt", 112'(cluster_count), 112'(8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
